// File: rtl/nand4_chk_pkg.sv
// Shared types and helpers for the four-input NAND response checker.
//   state_t      : checker FSM states
//   MISR_POLY    : feedback polynomial of the response signature register
//   nand4_expect : golden {e,f,g} for an applied vector {a,b,c,d}
package nand4_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;

    // vec = {a,b,c,d}, a in bit 3. Returns {e,f,g}.
    function automatic logic [2:0] nand4_expect(input logic [3:0] vec);
        logic e;
        logic f;
        logic g;
        e = ~(vec[3] & vec[2]);
        f = ~(vec[1] & vec[0]);
        g = ~(&vec);
        return {e, f, g};
    endfunction

endpackage

// File: rtl/nand4_misr.sv
// 16-bit multiple-input signature register with a 3-bit parallel input.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset, loads SEED
//   load   in   reload SEED (takes priority over enable)
//   enable in   compress data into the signature this cycle
//   data   in   3-bit response word {e,f,g}
//   sig    out  current signature
module nand4_misr
    import nand4_chk_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        enable,
    input  logic [2:0]  data,
    output logic [15:0] sig
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (enable) begin
            sig <= ({sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000)) ^ {13'b0, data};
        end
    end

endmodule

// File: rtl/nand4_response_checker.sv
// Response checker for a four-input NAND gate under test. Each accepted
// vector is registered (stage 1) and compared / compressed into the MISR
// one cycle later (stage 2). A FLUSH state drains stage 2 so that done
// rises only once every result is final.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               pulse: clear results and begin a run (IDLE/DONE only)
//   vec_valid           vec/e/f/g valid this cycle
//   vec                 applied stimulus {a,b,c,d}
//   e, f, g             gate-under-test outputs for vec
//   busy                high in RUN and FLUSH
//   done                high in DONE
//   pass                done with no mismatches
//   err_count           saturating count of mismatching vectors
//   first_err_valid     a mismatch has been seen this run
//   first_err_vec       vector of the first mismatch
//   vec_count           vectors accepted this run
//   signature           MISR over {e,f,g} of accepted vectors
module nand4_response_checker
    import nand4_chk_pkg::*;
#(
    parameter int          NUM_VECTORS = 16,
    parameter int          VCNT_W      = 8,
    parameter int          CNT_W       = 8,
    parameter logic [15:0] SIG_SEED    = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              vec_valid,
    input  logic [3:0]        vec,
    input  logic              e,
    input  logic              f,
    input  logic              g,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [3:0]        first_err_vec,
    output logic [VCNT_W-1:0] vec_count,
    output logic [15:0]       signature
);

    localparam logic [VCNT_W-1:0] NUM_V  = VCNT_W'(NUM_VECTORS);
    localparam logic [VCNT_W-1:0] LAST_V = VCNT_W'(NUM_VECTORS - 1);

    state_t      state_reg;
    logic        s1_valid_reg;
    logic [3:0]  s1_vec_reg;
    logic [2:0]  s1_efg_reg;

    logic        start_ok;
    logic        accept;
    logic        mismatch;

    // start is honoured only when no run is in progress.
    assign start_ok = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign accept   = vec_valid && (state_reg == RUN) && (vec_count < NUM_V);
    assign mismatch = s1_valid_reg && (s1_efg_reg != nand4_expect(s1_vec_reg));
    assign pass     = done && (err_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            vec_count       <= '0;
            s1_valid_reg    <= 1'b0;
            s1_vec_reg      <= 4'h0;
            s1_efg_reg      <= 3'b000;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 4'h0;
        end else begin
            // Stage 1: capture the accepted vector and its response.
            s1_valid_reg <= accept;
            if (accept) begin
                s1_vec_reg <= vec;
                s1_efg_reg <= {e, f, g};
            end

            case (state_reg)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state_reg <= RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        vec_count <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        vec_count <= vec_count + 1'b1;
                        // Leave RUN on the same edge that counts the last vector.
                        if (vec_count == LAST_V) begin
                            state_reg <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Stage 2 finishes the last vector on this edge.
                    state_reg <= DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase

            // Stage 2: compare results. start_ok and mismatch never coincide,
            // since stage 1 is empty in IDLE and DONE.
            if (start_ok) begin
                err_count       <= '0;
                first_err_valid <= 1'b0;
                first_err_vec   <= 4'h0;
            end else if (mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_vec   <= s1_vec_reg;
                end
            end
        end
    end

    nand4_misr #(
        .SEED (SIG_SEED)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .load   (start_ok),
        .enable (s1_valid_reg),
        .data   (s1_efg_reg),
        .sig    (signature)
    );

endmodule
